// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: access op codes,
// controller states and the op-to-byte-count helper.
package mem_ctrl_pkg;

  typedef enum logic [4:0] {
    OP_LB  = 5'd0,
    OP_LH  = 5'd1,
    OP_LW  = 5'd2,
    OP_LBU = 5'd3,
    OP_LHU = 5'd4,
    OP_SB  = 5'd5,
    OP_SH  = 5'd6,
    OP_SW  = 5'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_FETCH,
    S_DONE
  } state_e;

  function automatic logic [2:0] op_len(input logic [4:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_len = 3'd1;
      OP_LH, OP_LHU, OP_SH: op_len = 3'd2;
      default:              op_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bundle between LSB + ifetch and the memory controller,
// together with the byte-wide RAM/IO pins.
interface mem_ctrl_if;
  logic        load_store_sgn;
  logic        load_or_store;
  logic [4:0]  load_store_op;
  logic [31:0] load_store_addr;
  logic [31:0] load_store_data;
  logic        mem_valid;
  logic [31:0] mem_res;
  logic        ifetch_req;
  logic [31:0] ifetch_pc;
  logic        ifetch_valid;
  logic [31:0] ifetch_inst;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport master (
    output load_store_sgn, load_or_store, load_store_op, load_store_addr, load_store_data,
    output ifetch_req, ifetch_pc, mem_din,
    input  mem_valid, mem_res, ifetch_valid, ifetch_inst, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  load_store_sgn, load_or_store, load_store_op, load_store_addr, load_store_data,
    input  ifetch_req, ifetch_pc, mem_din,
    output mem_valid, mem_res, ifetch_valid, ifetch_inst, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl_ext.sv
// Load result extension: sign-extends LB/LH, zero-extends LBU/LHU, passes LW.
module mem_ext
  import mem_ctrl_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] raw,
  output logic [31:0] res
);
  always_comb begin
    case (op)
      OP_LB:   res = {{24{raw[7]}}, raw[7:0]};
      OP_LH:   res = {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  res = {24'b0, raw[7:0]};
      OP_LHU:  res = {16'b0, raw[15:0]};
      default: res = raw;
    endcase
  end
endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller for LSB loads/stores and instruction fetch.
// Optional macro IO_BUFFER_FULL_EN: stall IO-region stores while the UART buffer is full.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  input  logic      rollback,
  input  logic      io_buffer_full,
  mem_ctrl_if.slave bus
);
  state_e      state, state_n;
  logic [2:0]  cnt, cnt_n, len, nb;
  logic [4:0]  op_q, op_n;
  logic [31:0] addr_q, addr_n, data_q, data_n, raw_q, raw_n, raw_cap, ext_res;
  logic [31:0] a_q, a_n, res_q, res_n, inst_q, inst_n;
  logic [7:0]  dout_q, dout_n, din_hold, din;
  logic        wr_q, wr_n, valid_q, valid_n, fvalid_q, fvalid_n, rdy_q;
  logic        io_gate, io_gate_req;

  // The RAM keeps running while rdy is low: hold the byte that was in flight
  // when the freeze began and present it on the first cycle after resuming.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q    <= 1'b0;
      din_hold <= '0;
    end else begin
      rdy_q <= rdy;
      if (rdy_q) din_hold <= bus.mem_din;
    end
  end
  assign din = rdy_q ? bus.mem_din : din_hold;

`ifdef IO_BUFFER_FULL_EN
  logic io_hold;
  always_ff @(posedge clk) begin
    if (rst)      io_hold <= 1'b0;
    else if (rdy) io_hold <= io_buffer_full;
  end
  assign io_gate_req = (bus.load_store_addr[17:16] == IO_ADDR_HI) && (io_buffer_full || io_hold);
  assign io_gate     = (addr_q[17:16] == IO_ADDR_HI) && (io_buffer_full || io_hold);
`else
  logic unused_io;
  assign unused_io   = ^{io_buffer_full, IO_ADDR_HI};
  assign io_gate_req = 1'b0;
  assign io_gate     = 1'b0;
`endif

  assign len = op_len(op_q);
  // In STORE, cnt is the byte on the bus this cycle (if mem_wr) or the one still pending.
  assign nb  = wr_q ? cnt + 3'd1 : cnt;

  always_comb begin
    raw_cap = raw_q;
    case (cnt)
      3'd1:    raw_cap[7:0]   = din;
      3'd2:    raw_cap[15:8]  = din;
      3'd3:    raw_cap[23:16] = din;
      3'd4:    raw_cap[31:24] = din;
      default: ;
    endcase
  end

  mem_ext u_ext (
    .op  (op_q),
    .raw (raw_cap),
    .res (ext_res)
  );

  always_ff @(posedge clk) begin
    if (rst)      state <= S_IDLE;
    else if (rdy) state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (!rollback) begin
          if (bus.load_store_sgn)  state_n = bus.load_or_store ? S_LOAD : S_STORE;
          else if (bus.ifetch_req) state_n = S_FETCH;
        end
      end
      S_LOAD, S_FETCH: begin
        if (rollback)        state_n = S_IDLE;
        else if (cnt == len) state_n = S_DONE;
      end
      S_STORE: if (nb == len) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_n    = cnt;
    op_n     = op_q;
    addr_n   = addr_q;
    data_n   = data_q;
    raw_n    = raw_q;
    a_n      = '0;
    dout_n   = '0;
    wr_n     = 1'b0;
    valid_n  = 1'b0;
    fvalid_n = 1'b0;
    res_n    = '0;
    inst_n   = '0;
    case (state)
      S_IDLE: begin
        if (!rollback && bus.load_store_sgn) begin
          addr_n = bus.load_store_addr;
          data_n = bus.load_store_data;
          op_n   = bus.load_store_op;
          cnt_n  = '0;
          raw_n  = '0;
          if (bus.load_or_store) begin
            a_n = bus.load_store_addr;
          end else if (!io_gate_req) begin
            a_n    = bus.load_store_addr;
            dout_n = bus.load_store_data[7:0];
            wr_n   = 1'b1;
          end
        end else if (!rollback && bus.ifetch_req) begin
          addr_n = bus.ifetch_pc;
          op_n   = OP_LW;
          cnt_n  = '0;
          raw_n  = '0;
          a_n    = bus.ifetch_pc;
        end
      end
      S_LOAD, S_FETCH: begin
        if (rollback) begin
          cnt_n = '0;
        end else begin
          raw_n = raw_cap;
          cnt_n = cnt + 3'd1;
          if (cnt == len) begin
            if (state == S_FETCH) begin
              fvalid_n = 1'b1;
              inst_n   = raw_cap;
            end else begin
              valid_n = 1'b1;
              res_n   = ext_res;
            end
          end else if (3'(cnt + 3'd1) < len) begin
            a_n = addr_q + {29'b0, 3'(cnt + 3'd1)};
          end
        end
      end
      S_STORE: begin
        if (nb == len) begin
          valid_n = 1'b1;
        end else begin
          cnt_n = nb;
          if (!io_gate) begin
            a_n    = addr_q + {29'b0, nb};
            dout_n = 8'(data_q >> {nb[1:0], 3'b000});
            wr_n   = 1'b1;
          end
        end
      end
      S_DONE:  cnt_n = '0;
      default: cnt_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      raw_q    <= '0;
      a_q      <= '0;
      dout_q   <= '0;
      wr_q     <= 1'b0;
      valid_q  <= 1'b0;
      fvalid_q <= 1'b0;
      res_q    <= '0;
      inst_q   <= '0;
    end else if (rdy) begin
      cnt      <= cnt_n;
      op_q     <= op_n;
      addr_q   <= addr_n;
      data_q   <= data_n;
      raw_q    <= raw_n;
      a_q      <= a_n;
      dout_q   <= dout_n;
      wr_q     <= wr_n;
      valid_q  <= valid_n;
      fvalid_q <= fvalid_n;
      res_q    <= res_n;
      inst_q   <= inst_n;
    end
  end

  assign bus.mem_a        = a_q;
  assign bus.mem_dout     = dout_q;
  assign bus.mem_wr       = wr_q;
  assign bus.mem_valid    = valid_q;
  assign bus.mem_res      = res_q;
  assign bus.ifetch_valid = fvalid_q;
  assign bus.ifetch_inst  = inst_q;

endmodule
